negate_arbiter: RTL and testbench
=================================

# negate_arbiter

Round-robin controller that shares one `negate_sign` datapath (16-bit two's-complement negation) among `NREQ` requesters in the CALU. It accepts operands over per-requester valid/ready handshakes and drives the shared unit's `in_num` from a registered operand. It captures `out_num` and returns each result, tagged with the requester ID, over a single valid/ready result port with backpressure.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester ID.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: requester i has an operand pending.
- `req_data` in 16*NREQ: operand of requester i in bits [16i+15:16i].
- `req_ready` out NREQ: grant; a transfer occurs when `req_valid[i] & req_ready[i]` at a rising edge.
- `neg_in` out 16: drives `in_num` of the shared `negate_sign`.
- `neg_out` in 16: from `out_num` of the shared `negate_sign`; combinational in `neg_in`.
- `res_valid` out 1: result available.
- `res_data` out 16: negated operand.
- `res_id` out IDW: index of the requester that issued the result.
- `res_ovf` out 1: the operand was 16'h8000, which has no positive counterpart.
- `res_ready` in 1: consumer accepts the result when `res_valid & res_ready` at a rising edge.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, HOLD.
- **IDLE:**
  - If any `req_valid` is high, grant the first valid requester searching upward (with wrap) from `last_gnt+1`.
  - Assert `req_ready` one-hot for that requester, combinationally, in the same cycle.
  - On the edge: latch the operand into `op_reg`, latch the index into `id_reg`, set `last_gnt` to the granted index, go to ISSUE.
- **ISSUE:**
  - `neg_in = op_reg`.
  - On the edge: capture `neg_out` into `res_data` (see Configuration), set `res_ovf = (op_reg == 16'h8000)`, set `res_id = id_reg`, set `res_valid` = 1, go to HOLD.
- **HOLD:**
  - `res_valid` stays 1. `res_data`, `res_id` and `res_ovf` stay stable until the result is accepted.
  - If `res_ready` = 0: all `req_ready` = 0 and the FSM stays in HOLD.
  - If `res_ready` = 1 and no request is valid: clear `res_valid`, go to IDLE.
  - If `res_ready` = 1 and a request is valid: grant exactly as in IDLE, in the same cycle; clear `res_valid`, latch the new operand, go to ISSUE (back-to-back issue).
- **Arbitration:**
  - `req_ready` is never asserted in ISSUE.
  - At most one `req_ready` bit is high in any cycle.
  - A requester that drops `req_valid` without being granted is simply skipped; no state changes on its account.
- **Arithmetic:**
  - Negation is modulo 2^16, as performed by the shared unit.
  - 16'h0000 -> 16'h0000 with `res_ovf` = 0.
  - 16'h8000 sets `res_ovf` = 1.

## Timing
- **Reset values:**
  - FSM = IDLE; `res_valid` = 0; `res_data` = 0; `res_id` = 0; `res_ovf` = 0; `busy` = 0; `req_ready` = 0.
  - `op_reg` = 0, so `neg_in` = 0.
  - `last_gnt` = NREQ-1, so requester 0 has priority first.
- **Latency:** operand accepted at edge N; `res_valid` rises after edge N+1 and is visible during cycle N+2.
- **Throughput:** one result per 2 cycles when `res_ready` is held at 1.
- **Fairness:** with all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0.
- **Reset mid-operation:** reset asserted in ISSUE or HOLD discards the in-flight operand and result. No result is emitted for it, and the FSM resumes in IDLE.
- **Timing paths:** `req_ready` depends combinationally on `req_valid`, `res_ready` and state. No combinational path exists from `req_data` to any output except through `op_reg`.

## Configuration
- **`NEG_SAT_EN` defined:** when `op_reg == 16'h8000`, `res_data` = 16'h7FFF (saturated) and `res_ovf` = 1. All other operands behave as without the macro.
- **`NEG_SAT_EN` undefined:** `res_data` = `neg_out` unconditionally (16'h8000 -> 16'h8000), with `res_ovf` = 1 for that operand.

## Test plan
- **Single request:** reset, then requester 0 sends 16'd2 -> `res_valid` in the second cycle after acceptance, `res_data` = 16'hFFFE, `res_id` = 0, `res_ovf` = 0.
- **Round-robin:** all four requesters valid with operands 4, 5, -3, 0 and `res_ready` = 1 -> results in order id 0,1,2,3 with data 16'hFFFC, 16'hFFFB, 16'h0003, 16'h0000, issued every 2 cycles.
- **Backpressure:** `res_ready` = 0 for 5 cycles while requester 1 is valid -> `res_data`, `res_id` and `res_ovf` stay stable and `req_ready` = 0 throughout; raising `res_ready` issues requester 1 in the same cycle.
- **Overflow:** operand 16'h8000 -> `res_ovf` = 1; `res_data` = 16'h7FFF with `NEG_SAT_EN`, 16'h8000 without it.
- **Reset mid-operation:** assert `rst` while in ISSUE -> all outputs return to their reset values asynchronously, no result is emitted afterwards, and the next grant goes to requester 0.

Source files
------------

// File: rtl/negate_arbiter.sv
// ============================================================================
//  Module      : negate_arbiter
//  Description : Round-robin front end for one shared negate_sign unit
//                (16-bit two's-complement negation). Operands arrive over
//                per-requester valid/ready handshakes. Each negated result is
//                returned over a single valid/ready result port, tagged with
//                the ID of the requester that sent the operand.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ        number of requesters (2..8)
//    IDW         requester ID width, $clog2(NREQ)
//  Ports
//    clk         rising-edge clock
//    rst         asynchronous active-high reset
//    req_valid   [NREQ]     requester i has an operand pending
//    req_data    [16*NREQ]  operand of requester i in bits [16i+15:16i]
//    req_ready   [NREQ]     one-hot grant (combinational)
//    neg_in      [16]       to in_num of the shared negate_sign
//    neg_out     [16]       from out_num of the shared negate_sign
//    res_valid   result available
//    res_data    [16]       negated operand
//    res_id      [IDW]      issuing requester
//    res_ovf     operand was 16'h8000
//    res_ready   consumer accepts the result
//    busy        FSM is not idle
//  Build option
//    NEG_SAT_EN  when defined, 16'h8000 saturates to 16'h7FFF
// ============================================================================
`default_nettype none

module negate_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          neg_in,
    input  logic [15:0]          neg_out,
    output logic                 res_valid,
    output logic [15:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 res_ovf,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam logic [15:0] C_MOST_NEG = 16'h8000;
    localparam logic [15:0] C_SAT_POS  = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,     state_d;
    logic [15:0]     op_q,        op_d;
    logic [IDW-1:0]  id_q,        id_d;
    logic [IDW-1:0]  last_gnt_q,  last_gnt_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q,  res_data_d;
    logic [IDW-1:0]  res_id_q,    res_id_d;
    logic            res_ovf_q,   res_ovf_d;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or after last_gnt+1
    // ------------------------------------------------------------------
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [15:0]     gnt_data;
    logic            gnt_window;   // FSM is able to accept an operand now
    logic            gnt_fire;

    always_comb begin
        logic [IDW-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_gnt_q) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Operand mux, driven only by the selected index.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_data = req_data[16*i +: 16];
            end
        end
    end

    // A new operand can be taken in IDLE, or in HOLD in the same cycle the
    // pending result leaves (back-to-back issue).
    assign gnt_window = (state_q == IDLE) || ((state_q == HOLD) && res_ready);
    assign gnt_fire   = gnt_window && gnt_any;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = gnt_fire && (gnt_idx == IDW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        last_gnt_d  = last_gnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            IDLE: begin
                if (gnt_fire) begin
                    op_d       = gnt_data;
                    id_d       = gnt_idx;
                    last_gnt_d = gnt_idx;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
`ifdef NEG_SAT_EN
                res_data_d = (op_q == C_MOST_NEG) ? C_SAT_POS : neg_out;
`else
                res_data_d = neg_out;
`endif
                res_ovf_d   = (op_q == C_MOST_NEG);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end

            HOLD: begin
                // Result fields stay put until the consumer takes them.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (gnt_fire) begin
                        op_d       = gnt_data;
                        id_d       = gnt_idx;
                        last_gnt_d = gnt_idx;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            id_q        <= '0;
            // Priority pointer starts at the top so requester 0 wins first.
            last_gnt_q  <= IDW'(NREQ - 1);
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_gnt_q  <= last_gnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign neg_in    = op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_negate_arbiter.sv
`default_nettype none

module tb_negate_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [15:0]       neg_in;
    logic [15:0]       neg_out;
    logic              res_valid;
    logic [15:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;
    logic              res_ready;
    logic              busy;

    // Model of the shared negate_sign unit: modulo-2^16 negation.
    assign neg_out = 16'(0) - neg_in;

    negate_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .neg_in    (neg_in),
        .neg_out   (neg_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          id;
        logic [15:0] op;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

`ifdef NEG_SAT_EN
    localparam logic [15:0] MOST_NEG_RESULT = 16'h7FFF;
`else
    localparam logic [15:0] MOST_NEG_RESULT = 16'h8000;
`endif

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 16'd2,    16'hFFFE, 1'b0};
        vecs[1] = '{1, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{2, 16'h8000, MOST_NEG_RESULT, 1'b1};
        vecs[3] = '{3, 16'h7FFF, 16'h8001, 1'b0};
        vecs[4] = '{0, 16'hFFFF, 16'h0001, 1'b0};
        vecs[5] = '{1, 16'h0001, 16'hFFFF, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;

        // ---------------- Reset state ----------------
        #3;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        check("rst_res_ovf",   32'(res_ovf),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_neg_in",    32'(neg_in),    32'd0);
        step();
        step();
        rst = 1'b0;

        // ---------------- Single-request vectors ----------------
        for (int v = 0; v < 6; v++) begin
            res_ready = 1'b0;
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            req_data[16*vecs[v].id +: 16] = vecs[v].op;
            #1;
            check($sformatf("v%0d_grant", v), 32'(req_ready), 32'(1 << vecs[v].id));
            step();
            req_valid = '0;
            #1;
            check($sformatf("v%0d_issue_busy", v), 32'(busy), 32'd1);
            check($sformatf("v%0d_issue_neg_in", v), 32'(neg_in), 32'(vecs[v].op));
            check($sformatf("v%0d_issue_res_valid", v), 32'(res_valid), 32'd0);
            step();
            check($sformatf("v%0d_res_valid", v), 32'(res_valid), 32'd1);
            check($sformatf("v%0d_res_data", v), 32'(res_data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_res_id", v), 32'(res_id), 32'(vecs[v].id));
            check($sformatf("v%0d_res_ovf", v), 32'(res_ovf), 32'(vecs[v].exp_ovf));
            res_ready = 1'b1;
            step();
            check($sformatf("v%0d_done_valid", v), 32'(res_valid), 32'd0);
            check($sformatf("v%0d_done_busy", v), 32'(busy), 32'd0);
        end
        res_ready = 1'b0;

        // ---------------- Round-robin, fresh reset ----------------
        begin
            logic [15:0] rr_exp[4];
            int n;
            int last_cyc;
            rr_exp[0] = 16'hFFFC;
            rr_exp[1] = 16'hFFFB;
            rr_exp[2] = 16'h0003;
            rr_exp[3] = 16'h0000;
            rst = 1'b1;
            step();
            req_data  = {16'd0, 16'hFFFD, 16'd5, 16'd4};
            req_valid = 4'b1111;
            res_ready = 1'b1;
            rst = 1'b0;
            n = 0;
            last_cyc = -1;
            for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
                step();
                if (res_valid) begin
                    check($sformatf("rr%0d_id", n), 32'(res_id), 32'(n));
                    check($sformatf("rr%0d_data", n), 32'(res_data), 32'(rr_exp[n]));
                    if (n > 0) check($sformatf("rr%0d_gap", n), 32'(cyc - last_cyc), 32'd2);
                    last_cyc = cyc;
                    n++;
                    if (n == 4) req_valid = '0;
                end
            end
            check("rr_count", 32'(n), 32'd4);
            step();
            check("rr_idle", 32'(busy), 32'd0);
        end

        // ---------------- Backpressure ----------------
        res_ready = 1'b0;
        req_valid = 4'b0100;
        req_data[32 +: 16] = 16'd10;
        step();
        req_valid = 4'b0010;
        req_data[16 +: 16] = 16'd7;
        #1;
        check("bp_issue_no_grant", 32'(req_ready), 32'd0);
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_data", c), 32'(res_data), 32'hFFF6);
            check($sformatf("bp%0d_id", c), 32'(res_id), 32'd2);
            check($sformatf("bp%0d_ovf", c), 32'(res_ovf), 32'd0);
            check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check("bp_b2b_valid_low", 32'(res_valid), 32'd0);
        check("bp_b2b_neg_in", 32'(neg_in), 32'd7);
        step();
        check("bp_b2b_res_valid", 32'(res_valid), 32'd1);
        check("bp_b2b_data", 32'(res_data), 32'hFFF9);
        check("bp_b2b_id", 32'(res_id), 32'd1);
        step();
        check("bp_end_idle", 32'(busy), 32'd0);

        // ---------------- Reset mid-operation ----------------
        res_ready = 1'b0;
        req_valid = 4'b1000;
        req_data[48 +: 16] = 16'd1;
        step();
        req_valid = '0;
        check("mid_in_issue", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_neg_in", 32'(neg_in), 32'd0);
        check("mid_res_data", 32'(res_data), 32'd0);
        check("mid_res_ovf", 32'(res_ovf), 32'd0);
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("mid_quiet%0d", c), 32'(res_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        check("mid_next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
